mem_bus_responder: RTL

//  Memory-side responder for the CPU's single shared (von Neumann) memory bus. Accepts one

---
 rtl/mem_bus_responder.sv | 82 ++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: wait-state memory responder with valid/ready request and held response
module mem_bus_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int COUNT_WIDTH = 16,
  parameter     INIT_FILE   = ""
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_address,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_error,
  output logic [COUNT_WIDTH-1:0] read_count,
  output logic [COUNT_WIDTH-1:0] write_count
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0] wcnt;
  logic accept, go, c_write, in_range;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [IW-1:0] idx;
  assign req_ready = state == IDLE;
  always_comb begin
    accept   = req_ready && req_valid;
    go       = accept ? (WAIT_STATES == 0) : (state == WAIT && wcnt == 4'd0);
    c_write  = accept ? req_write : lat_write;
    c_addr   = accept ? req_address : lat_addr;
    c_wdata  = accept ? req_wdata : lat_wdata;
    in_range = 32'(c_addr) < 32'(DEPTH);
    idx      = c_addr[IW-1:0];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
      wcnt        <= 4'd0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_address;
        lat_wdata <= req_wdata;
        wcnt      <= 4'(WAIT_STATES - 1);
        state     <= WAIT;
      end
      if (state == WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
      if (go) begin
        state     <= RESPOND;
        rsp_valid <= 1'b1;
        rsp_error <= !in_range;
        rsp_data  <= !in_range ? '0 : c_write ? c_wdata : mem[idx];
        if (in_range && c_write) mem[idx] <= c_wdata;
        if (c_write && !(&write_count)) write_count <= write_count + 1'b1;
        if (!c_write && !(&read_count)) read_count <= read_count + 1'b1;
      end
      if (state == RESPOND && rsp_ready) begin
        state     <= IDLE;
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule
